register_arbiter: RTL

REGISTER_ARBITER -- requirements
Module: register_arbiter

---
 rtl/register_arbiter_pkg.sv | 15 +
 rtl/register_arbiter_reg.sv | 20 ++
 rtl/register_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/register_arbiter_pkg.sv
// Shared definitions for the register arbiter: FSM encodings and default sizes.
package register_arbiter_pkg;

    // Arbiter FSM phases: wait for a request, grant the winner, acknowledge the commit.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } arb_state_t;

    // Default number of requesters and shared register width.
    localparam int DEFAULT_N_REQ = 4;
    localparam int DEFAULT_WIDTH = 16;

endpackage : register_arbiter_pkg

// File: rtl/register_arbiter_reg.sv
// Load-enabled storage register shared by all requesters; holds its value when load is low.
module register_arbiter_reg
    import register_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    output logic [WIDTH-1:0] out
);

    // Capture the input word on any edge where load is asserted.
    always_ff @(posedge clk) begin
        if (load) begin
            out <= in;
        end
    end

endmodule : register_arbiter_reg

// File: rtl/register_arbiter.sv
// Round-robin arbiter granting N_REQ requesters write access to one shared register.
// Each write takes three cycles (IDLE -> GRANT -> ACK); grants rotate starting after
// the most recently granted requester.
module register_arbiter
    import register_arbiter_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   in,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         ack,
    output logic [WIDTH-1:0]         out,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     valid
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE_HOT_0 = N_REQ'(1);

    arb_state_t        state;
    logic [IDX_W-1:0]  last;
    logic [IDX_W-1:0]  winner;
    logic [IDX_W-1:0]  search_start;
    logic [IDX_W-1:0]  pick_idx;
    logic [2*N_REQ-1:0] req_twice;
    logic [N_REQ-1:0]  req_rot;
    logic [WIDTH-1:0]  wr_data;
    logic [WIDTH-1:0]  reg_q;
    logic              load;

    // Rotate the request vector so the requester after 'last' sits at bit 0, then take the lowest set bit.
    always_comb begin
        search_start = last + 1'b1;
        req_twice    = {req, req};
        req_rot      = req_twice[search_start +: N_REQ];
        pick_idx     = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                pick_idx = search_start + IDX_W'(j);
            end
        end
    end

    // Arbiter FSM: latch the winner in IDLE, commit at the end of GRANT, pulse ack for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            gnt    <= '0;
            ack    <= '0;
            owner  <= '0;
            valid  <= 1'b0;
            last   <= IDX_W'(N_REQ - 1);
            winner <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= '0;
                    if (|req) begin
                        winner <= pick_idx;
                        gnt    <= ONE_HOT_0 << pick_idx;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    gnt   <= '0;
                    ack   <= ONE_HOT_0 << winner;
                    owner <= winner;
                    last  <= winner;
                    valid <= 1'b1;
                    state <= ACK;
                end
                ACK: begin
                    ack   <= '0;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    ack   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // The winner's data word feeds the storage; loading only in GRANT, and never while reset is high.
    assign wr_data = in[winner*WIDTH +: WIDTH];
    assign load    = (state == GRANT) && !reset;

    register_arbiter_reg #(
        .WIDTH(WIDTH)
    ) u_storage (
        .clk  (clk),
        .in   (wr_data),
        .load (load),
        .out  (reg_q)
    );

    // The storage block has no reset of its own, so the visible contents read as zero until a write commits.
    assign out = valid ? reg_q : '0;

endmodule : register_arbiter
